// File: rtl/sa_run_controller.sv
// Run sequencer for the systolic array: loads weight/data buffers from one byte
// stream, enables the array for k+ROW+COL-2 cycles, then streams results out LSB-first.
module sa_run_controller #(
    parameter int ROW    = 9,
    parameter int COL    = 32,
    parameter int W_DATA = 8,
    parameter int W_ACC  = 32,
    parameter int K_MAX  = 16,
    parameter int W_K    = 5,
    parameter int W_ADDR = 10
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [W_K-1:0]               i_k,
    input  logic [W_DATA-1:0]            s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         o_wsel,
    output logic                         o_wr_en,
    output logic [W_ADDR-1:0]            o_wr_addr,
    output logic [W_DATA-1:0]            o_wr_data,
    output logic                         o_sa_clr,
    output logic                         o_sa_en,
    output logic                         o_res_rd_en,
    output logic [$clog2(ROW*COL)-1:0]   o_res_idx,
    input  logic [W_ACC-1:0]             i_res_data,
    output logic [W_DATA-1:0]            m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int NB    = W_ACC / W_DATA;
    localparam int NRES  = ROW * COL;
    localparam int MAXRC = (ROW > COL) ? ROW : COL;
    localparam int CLD   = MAXRC * K_MAX;
    localparam int CCMP  = K_MAX + ROW + COL;
    localparam int CMAX  = (CLD > CCMP) ? CLD : CCMP;
    localparam int W_CNT = $clog2(CMAX + 1);
    localparam int W_IDX = $clog2(NRES + 1);
    localparam int W_RI  = $clog2(NRES);
    localparam int W_B   = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, COMPUTE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [W_K-1:0]      k_q, k_d;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d, wsel_q, wsel_d;
    logic [W_ADDR-1:0]   wr_addr_q, wr_addr_d;
    logic [W_DATA-1:0]   wr_data_q, wr_data_d;
    logic                sa_clr_q, sa_clr_d, err_q, err_d;
    logic [W_IDX-1:0]    idx_q, idx_d;
    logic [W_B-1:0]      bcnt_q, bcnt_d;
    logic                cap_q, cap_d, have_q, have_d;
    logic [W_ACC-1:0]    shreg_q, shreg_d;

    logic [W_CNT-1:0]    k_ext, lim_w, lim_d, lim_c, lim_ld, cnt_inc;
    logic [W_ACC-1:0]    cur_word;
    logic                k_ok, xfer, last_byte, rd_en;

    assign k_ext   = W_CNT'(k_q);
    assign lim_w   = W_CNT'(COL) * k_ext;
    assign lim_d   = W_CNT'(ROW) * k_ext;
    assign lim_c   = k_ext + W_CNT'(ROW + COL - 2);
    assign lim_ld  = (state_q == LOAD_W) ? lim_w : lim_d;
    assign cnt_inc = cnt_q + W_CNT'(1);
    assign k_ok    = (i_k != '0) && (i_k <= W_K'(K_MAX));

    // The word being read arrives on i_res_data in the capture cycle; its first
    // byte is forwarded directly so back-to-back words leave no bubble.
    assign cur_word  = cap_q ? i_res_data : shreg_q;
    assign m_data    = cur_word[W_DATA-1:0];
    assign m_valid   = (state_q == DRAIN) && (cap_q || have_q);
    assign xfer      = m_valid && m_ready;
    assign last_byte = (bcnt_q == W_B'(NB - 1));

    assign s_ready     = (state_q == LOAD_W) || (state_q == LOAD_D);
    assign o_sa_en     = (state_q == COMPUTE);
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_res_rd_en = rd_en;
    assign o_res_idx   = W_RI'(idx_q);
    assign o_wr_en     = wr_en_q;
    assign o_wsel      = wsel_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_sa_clr    = sa_clr_q;
    assign o_err       = err_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wsel_d    = wsel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        sa_clr_d  = 1'b0;
        err_d     = 1'b0;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        cap_d     = 1'b0;
        have_d    = have_q;
        shreg_d   = shreg_q;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (k_ok) begin
                        k_d      = i_k;
                        cnt_d    = '0;
                        sa_clr_d = 1'b1;
                        state_d  = LOAD_W;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_W, LOAD_D: begin
                if (s_valid) begin
                    wr_en_d   = 1'b1;
                    wsel_d    = (state_q == LOAD_D);
                    wr_addr_d = W_ADDR'(cnt_q);
                    wr_data_d = s_data;
                    if (cnt_inc == lim_ld) begin
                        cnt_d   = '0;
                        state_d = (state_q == LOAD_W) ? LOAD_D : COMPUTE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            COMPUTE: begin
                if (cnt_inc == lim_c) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (last_byte) begin
                        have_d  = 1'b0;
                        bcnt_d  = '0;
                        shreg_d = '0;
                        if (idx_q == W_IDX'(NRES)) state_d = DONE;
                        else                       rd_en   = 1'b1;
                    end else begin
                        have_d  = 1'b1;
                        bcnt_d  = W_B'(bcnt_q + 1'b1);
                        shreg_d = cur_word >> W_DATA;
                    end
                end else if (cap_q) begin
                    have_d  = 1'b1;
                    shreg_d = cur_word;
                end else if (!have_q) begin
                    rd_en = 1'b1;  // first read on entry to DRAIN
                end
                if (rd_en) begin
                    idx_d = W_IDX'(idx_q + 1'b1);
                    cap_d = 1'b1;
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wsel_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sa_clr_q  <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            cap_q     <= 1'b0;
            have_q    <= 1'b0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wsel_q    <= wsel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sa_clr_q  <= sa_clr_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            cap_q     <= cap_d;
            have_q    <= have_d;
            shreg_q   <= shreg_d;
        end
    end

endmodule

// File: tb/tb_sa_run_controller.sv
// Directed bench for sa_run_controller on a 2x2 array, 32-bit results, K_MAX=4.
module tb_sa_run_controller;

    localparam int ROW = 2, COL = 2, W_DATA = 8, W_ACC = 32, K_MAX = 4, W_K = 3, W_ADDR = 4;
    localparam int NB = W_ACC / W_DATA;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic [W_K-1:0]    i_k = '0;
    logic [7:0]        s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              o_wsel, o_wr_en;
    logic [W_ADDR-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;
    logic              o_sa_clr, o_sa_en, o_res_rd_en;
    logic [1:0]        o_res_idx;
    logic [31:0]       i_res_data = '0;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic              o_busy, o_done, o_err;

    int checks = 0;
    int errors = 0;

    sa_run_controller #(.ROW(ROW), .COL(COL), .W_DATA(W_DATA), .W_ACC(W_ACC),
                        .K_MAX(K_MAX), .W_K(W_K), .W_ADDR(W_ADDR)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_k(i_k),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .o_wsel(o_wsel), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_sa_clr(o_sa_clr), .o_sa_en(o_sa_en), .o_res_rd_en(o_res_rd_en),
        .o_res_idx(o_res_idx), .i_res_data(i_res_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Result memory: synchronous read, word = 0xAABBCC00 + index
    always @(posedge clk)
        if (o_res_rd_en) i_res_data <= 32'hAABBCC00 + {30'd0, o_res_idx};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({s_ready, o_wsel, o_wr_en, o_wr_addr, o_wr_data, o_sa_clr, o_sa_en,
                    o_res_rd_en, o_res_idx, m_data, m_valid, o_busy, o_done, o_err});
    endfunction

    task automatic err_start(input int k);
        @(negedge clk); i_start = 1'b1; i_k = W_K'(k);
        @(negedge clk); i_start = 1'b0; #1;
        chk("err_pulse", 64'(o_err), 64'd1);
        chk("err_busy", 64'(o_busy), 64'd0);
        chk("err_no_write", 64'(o_wr_en), 64'd0);
        @(negedge clk); #1;
        chk("err_one_cycle", 64'({o_err, o_busy, s_ready, o_wr_en}), 64'd0);
    endtask

    task automatic run(input int k, input bit tog, input bit stall, input bit poke, input int abort_at);
        int nw, nd, nb, wn, sent, rn, bn, en, scnt;
        bit prev_hs, prev_stall, finished;
        logic [7:0]  prev_md, exp_b;
        logic [31:0] word;
        nw = COL * k; nd = ROW * k; nb = ROW * COL * NB;
        wn = 0; sent = 0; rn = 0; bn = 0; en = 0; scnt = 0;
        prev_hs = 0; prev_stall = 0; finished = 0; prev_md = '0;
        @(negedge clk); i_start = 1'b1; i_k = W_K'(k); m_ready = 1'b1; #1;
        chk("busy_before_start", 64'(o_busy), 64'd0);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (abort_at >= 0 && bn == abort_at) begin
                i_rst = 1'b1; i_start = 1'b0; s_valid = 1'b0; #1;
                chk("abort_outputs_zero", all_outs(), 64'd0);
                @(negedge clk); i_rst = 1'b0;
                repeat (4) begin
                    @(negedge clk); #1;
                    chk("no_output_after_abort", 64'({m_valid, o_busy, o_wr_en, o_res_rd_en}), 64'd0);
                end
                return;
            end
            i_start = poke && (en == 2);
            s_valid = (sent < nw + nd) && (!tog || (cyc % 2 == 0));
            s_data  = 8'(sent + 1);
            m_ready = !(stall && bn == 6 && scnt < 3);
            if (!m_ready) scnt++;
            #1;
            if (cyc == 0 || o_sa_clr) chk("sa_clr_pulse", 64'(o_sa_clr), 64'(cyc == 0));
            if (o_wr_en || prev_hs) chk("wr_en_after_handshake", 64'(o_wr_en), 64'(prev_hs));
            if (o_wr_en) begin
                chk("wr_wsel", 64'(o_wsel), 64'(wn >= nw));
                chk("wr_addr", 64'(o_wr_addr), 64'((wn >= nw) ? wn - nw : wn));
                chk("wr_data", 64'(o_wr_data), 64'(wn + 1));
                wn++;
            end
            prev_hs = s_valid && s_ready;
            if (prev_hs) sent++;
            if (o_sa_en) en++;
            if (o_sa_en || m_valid) chk("s_ready_low", 64'(s_ready), 64'd0);
            if (o_err) chk("no_err_in_run", 64'(o_err), 64'd0);
            if (o_res_rd_en) begin
                chk("res_idx", 64'(o_res_idx), 64'(rn));
                rn++;
            end
            if (prev_stall) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(prev_md));
            end
            if (!stall && bn > 0 && bn < nb) chk("no_gap", 64'(m_valid), 64'd1);
            if (m_valid && m_ready) begin
                word  = 32'hAABBCC00 + 32'(bn / NB);
                exp_b = 8'(word >> (8 * (bn % NB)));
                chk("m_data", 64'(m_data), 64'(exp_b));
                bn++;
            end
            prev_stall = m_valid && !m_ready;
            prev_md    = m_data;
            if (o_done) begin
                finished = 1;
                chk("n_writes", 64'(wn), 64'(nw + nd));
                chk("n_sa_en", 64'(en), 64'(k + ROW + COL - 2));
                chk("n_reads", 64'(rn), 64'(ROW * COL));
                chk("n_bytes", 64'(bn), 64'(nb));
            end
        end
        i_start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        if (!finished) begin
            chk("timeout_waiting_done", 64'd0, 64'd1);
        end else begin
            @(negedge clk); #1;
            chk("idle_after_done", 64'({o_busy, o_done, m_valid, s_ready, o_sa_en}), 64'd0);
        end
    endtask

    initial begin
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk); i_rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_after_reset", all_outs(), 64'd0);

        run(3, 1'b0, 1'b0, 1'b0, -1);  // back-to-back stream
        run(3, 1'b1, 1'b0, 1'b0, -1);  // s_valid every other cycle
        run(3, 1'b0, 1'b1, 1'b0, -1);  // m_ready low 3 cycles mid-word
        err_start(0);
        err_start(5);
        run(3, 1'b0, 1'b0, 1'b1, -1);  // i_start during COMPUTE
        run(3, 1'b0, 1'b0, 1'b0, 6);   // reset after 6 drained bytes
        run(3, 1'b0, 1'b0, 1'b0, -1);
        run(1, 1'b0, 1'b0, 1'b0, -1);  // minimum k
        run(4, 1'b1, 1'b0, 1'b0, -1);  // k = K_MAX

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
